fetch_cycle: RTL and testbench
==============================

# fetch_cycle

Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core. Owns the PC, issues one instruction-memory read at a time over a request/response handshake, and delivers `InstrD`/`PCD`/`PCPlus4D` to the decode stage. It honours decode stall and flush, and handles execute-stage redirects, including squashing an in-flight fetch. It is the producer side of the IF/ID interface that decode consumes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).
- `clock` input 1: the single clock.
- `reset` input 1: synchronous, active-high; takes effect on the `clock` rising edge.
- `StallD` input 1: hold IF/ID and the fetch pipeline.
- `FlushD` input 1: replace IF/ID contents with a bubble.
- `PCSrcE` input 1: redirect request from execute (taken branch or jump).
- `PCTargetE` input 32: redirect target.
- `IMemReq` output 1: read request valid.
- `IMemAddr` output 32: read address, word-aligned.
- `IMemReady` input 1: memory accepts the request this cycle.
- `IMemRValid` input 1: read data valid. Single-cycle pulse, at least 1 cycle after acceptance.
- `IMemRData` input 32: read data.
- `InstrD` output 32: IF/ID instruction.
- `PCD` output 32: IF/ID PC.
- `PCPlus4D` output 32: IF/ID PC+4.

## Operation
- Internal state:
  - `PCF` (32 bits).
  - FSM `REQ`/`WAIT`/`HOLD`.
  - `Squash` flag.
  - Hold buffer (32 bits).
- At most one outstanding memory request.
- Address rules:
  - `IMemAddr = PCF`.
  - Redirect loads `PCF <= {PCTargetE[31:2],2'b00}`.
  - PC increment is `PCF+4`, modulo 2^32; it wraps from 32'hFFFF_FFFC to 0.
- `IMemReq = (state==REQ) && !PCSrcE`.
- `REQ` state:
  - `PCSrcE` → redirect `PCF`, stay in `REQ`.
  - Else if `IMemReq && IMemReady` → `WAIT`, `Squash<=0`.
  - Else stay in `REQ`.
- `WAIT` state, no `IMemRValid`:
  - `PCSrcE` → redirect `PCF`, `Squash<=1`, stay in `WAIT`.
- `WAIT` state, `IMemRValid`:
  - If `Squash` or `PCSrcE`: discard the data, redirect on `PCSrcE`, `Squash<=0`, go to `REQ`.
  - Else if `!StallD`: deliver the data to IF/ID, `PCF<=PCF+4`, go to `REQ`.
  - Else: capture the data in the hold buffer, go to `HOLD`.
- `HOLD` state:
  - `PCSrcE` → discard the buffer, redirect, go to `REQ`.
  - Else if `!StallD` → deliver the buffer, `PCF<=PCF+4`, go to `REQ`.
  - Else stay in `HOLD`.
- IF/ID register update, priority order:
  1. `reset`: `InstrD=NOP_INSTR`, `PCD=0`, `PCPlus4D=0`.
  2. `FlushD`: load bubble, i.e. `NOP_INSTR`, 0, 0.
  3. `StallD`: hold.
  4. Delivery this cycle: load instruction, `PCF`, `PCF+4`.
  5. Otherwise: load bubble.
- A delivered instruction always carries the `PCF` it was fetched from. `PCF` changes only after delivery or on redirect.
- `FlushD` with a delivery in the same cycle: the flush wins. The FSM still treats the instruction as delivered. The hazard unit asserts `FlushD` only together with `PCSrcE`, so the redirect path discards the data anyway.
- Reset outputs:
  - `PCF=RESET_PC`, state `REQ`, `Squash=0`.
  - `IMemReq` is 1 in the first cycle after reset, with `IMemAddr=RESET_PC`.
- Reset mid-operation abandons any outstanding request. The bench memory model must drop its pending response on `reset`.

## Timing
- Zero-wait memory (`IMemReady=1`, `IMemRValid` one cycle after acceptance):
  - Request at cycle c, response at c+1, `InstrD` valid at c+2.
  - Next request at c+2.
  - Steady-state throughput is one instruction per 2 cycles.
- Redirect latency: `PCSrcE` at cycle c → request to `PCTargetE` issued at c+1 in `REQ`. From `WAIT`, it is issued the cycle after the squashed response.
- Memory wait states: `IMemReady` low holds `IMemReq`/`IMemAddr` stable. A late `IMemRValid` keeps the FSM in `WAIT`. Bubbles enter IF/ID every unstalled cycle meanwhile.
- All outputs are registered except `IMemReq` and `IMemAddr`. These are combinational from state, `PCF` and `PCSrcE`.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` constant.
  - Fetch FSM state encoding: `REQ`=2'd0, `WAIT`=2'd1, `HOLD`=2'd2.
- Single module; no sub-module is needed. The IF/ID register is inline.
- The bench supplies a behavioural instruction memory with configurable ready/response delay.

## Test plan
- Reset, zero-wait memory, `mem[i]=i*0x100+0x13`:
  - `IMemAddr` 0, 4, 8.
  - `InstrD` 0x13, 0x113, 0x213 at cycles 2, 4, 6, with matching `PCD` and `PCPlus4D`.
  - `NOP_INSTR` bubbles in between.
- `StallD` high for 3 cycles when a response arrives: FSM enters `HOLD`, IF/ID is held, no new request. After release, the buffered word is delivered with the correct `PCD` and the next request goes to `PCD+4`.
- `PCSrcE=1`, `PCTargetE=0x103` while in `WAIT` with response delay 3: the response is discarded, never appears on `InstrD`, and the next `IMemAddr` is 0x100.
- `PCSrcE` and `FlushD` in the same cycle as `IMemRValid`: IF/ID becomes the bubble (`NOP_INSTR`, 0, 0), and the next request goes to the target.
- `IMemReady` low for 4 cycles: `IMemReq` stays 1 with `IMemAddr` stable, and `InstrD` stays `NOP_INSTR`.
- PC wrap (`RESET_PC`=32'hFFFF_FFFC): the first delivery has `PCPlus4D=0`, and the next request goes to 0. A `reset` asserted while in `WAIT` returns to `REQ` at `RESET_PC` with all IF/ID outputs at their reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// Module : riscv_pkg
// Brief  : Constants and the fetch FSM state encoding shared by core stages.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_cycle.sv
//------------------------------------------------------------------------------
// Module : fetch_cycle
// Brief  : Instruction fetch with one outstanding read, plus the IF/ID register.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_cycle
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic         squash_q, squash_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  instr_q, pcd_q, pcplus4_q;

  logic         deliver;
  logic [31:0]  deliver_data;
  logic [31:0]  redirect_pc;
  logic [31:0]  pcf_plus4;

  assign redirect_pc = PCTargetE & ~32'h3;
  assign pcf_plus4   = pcf_q + 32'd4;

  assign IMemReq  = (state_q == REQ) && !PCSrcE;
  assign IMemAddr = pcf_q;

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    squash_d     = squash_q;
    hold_d       = hold_q;
    deliver      = 1'b0;
    deliver_data = IMemRData;
    case (state_q)
      REQ: begin
        if (PCSrcE) begin
          pcf_d = redirect_pc;
        end else if (IMemReady) begin
          state_d  = WAIT;
          squash_d = 1'b0;
        end
      end
      WAIT: begin
        if (!IMemRValid) begin
          // Redirect while a read is in flight: its response must be dropped.
          if (PCSrcE) begin
            pcf_d    = redirect_pc;
            squash_d = 1'b1;
          end
        end else if (squash_q || PCSrcE) begin
          if (PCSrcE) pcf_d = redirect_pc;
          squash_d = 1'b0;
          state_d  = REQ;
        end else if (!StallD) begin
          deliver = 1'b1;
          pcf_d   = pcf_plus4;
          state_d = REQ;
        end else begin
          hold_d  = IMemRData;
          state_d = HOLD;
        end
      end
      HOLD: begin
        deliver_data = hold_q;
        if (PCSrcE) begin
          pcf_d   = redirect_pc;
          state_d = REQ;
        end else if (!StallD) begin
          deliver = 1'b1;
          pcf_d   = pcf_plus4;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= REQ;
      pcf_q    <= RESET_PC;
      squash_q <= 1'b0;
      hold_q   <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      squash_q <= squash_d;
      hold_q   <= hold_d;
    end
  end

  // IF/ID register: flush beats stall, stall beats delivery.
  always_ff @(posedge clock) begin
    if (reset || FlushD) begin
      instr_q   <= NOP_INSTR;
      pcd_q     <= 32'd0;
      pcplus4_q <= 32'd0;
    end else if (!StallD) begin
      if (deliver) begin
        instr_q   <= deliver_data;
        pcd_q     <= pcf_q;
        pcplus4_q <= pcf_plus4;
      end else begin
        instr_q   <= NOP_INSTR;
        pcd_q     <= 32'd0;
        pcplus4_q <= 32'd0;
      end
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_cycle.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_cycle
// Brief  : Directed bench for fetch_cycle with a behavioural instruction memory.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_cycle;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        mem_ready = 1'b1;
  int          resp_delay = 1;

  logic        req1, rvalid1, req2, rvalid2;
  logic [31:0] addr1, rdata1, instr1, pcd1, pc4_1;
  logic [31:0] addr2, rdata2, instr2, pcd2, pc4_2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fetch_cycle dut (
    .clock(clock), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .IMemReq(req1), .IMemAddr(addr1), .IMemReady(mem_ready),
    .IMemRValid(rvalid1), .IMemRData(rdata1),
    .InstrD(instr1), .PCD(pcd1), .PCPlus4D(pc4_1)
  );

  fetch_cycle #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .IMemReq(req2), .IMemAddr(addr2), .IMemReady(mem_ready),
    .IMemRValid(rvalid2), .IMemRData(rdata2),
    .InstrD(instr2), .PCD(pcd2), .PCPlus4D(pc4_2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h100 + 32'h13;
  endfunction

  // Behavioural memories: response resp_delay cycles after acceptance, dropped on reset.
  logic        pend1 = 1'b0, pend2 = 1'b0;
  int          cnt1 = 0, cnt2 = 0;
  logic [31:0] paddr1 = 0, paddr2 = 0;

  assign rvalid1 = pend1 && (cnt1 == 1);
  assign rdata1  = rvalid1 ? mem_word(paddr1) : 32'hDEAD_BEEF;
  assign rvalid2 = pend2 && (cnt2 == 1);
  assign rdata2  = rvalid2 ? mem_word(paddr2) : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (reset) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      if (req1 && mem_ready) begin
        pend1 <= 1'b1; cnt1 <= resp_delay; paddr1 <= addr1;
      end else if (pend1) begin
        if (cnt1 == 1) pend1 <= 1'b0; else cnt1 <= cnt1 - 1;
      end
      if (req2 && mem_ready) begin
        pend2 <= 1'b1; cnt2 <= resp_delay; paddr2 <= addr2;
      end else if (pend2) begin
        if (cnt2 == 1) pend2 <= 1'b0; else cnt2 <= cnt2 - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench one step into cycle 0, the first cycle after reset.
  task automatic do_reset();
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req1 !== 1'b1) begin failures++; $display("FAIL reset_req got=%b want=1", req1); end
    checks++; if (addr1 !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h want=0", addr1); end
    checks++;
    if (instr1 !== NOP || pcd1 !== 32'd0 || pc4_1 !== 32'd0) begin
      failures++; $display("FAIL reset_ifid got=%h/%h/%h want=%h/0/0", instr1, pcd1, pc4_1, NOP);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] ei [1:6];
    logic [31:0] ep [1:6];
    logic [31:0] e4 [1:6];
    ei = '{NOP, 32'h13, NOP, 32'h113, NOP, 32'h213};
    ep = '{0, 0, 0, 4, 0, 8};
    e4 = '{0, 4, 0, 8, 0, 12};
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (instr1 !== ei[c] || pcd1 !== ep[c] || pc4_1 !== e4[c]) begin
        failures++;
        $display("FAIL fetch_c%0d got=%h/%h/%h want=%h/%h/%h", c, instr1, pcd1, pc4_1, ei[c], ep[c], e4[c]);
      end
      if (c == 2 || c == 4) begin
        checks++;
        if (req1 !== 1'b1 || addr1 !== 32'(c * 2)) begin
          failures++; $display("FAIL fetch_addr_c%0d got=%b/%h want=1/%h", c, req1, addr1, 32'(c * 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    StallD = 1'b1;
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++;
      if (req1 !== 1'b0 || instr1 !== NOP) begin
        failures++; $display("FAIL stall_hold_c%0d got=%b/%h want=0/%h", c, req1, instr1, NOP);
      end
    end
    tick();
    StallD = 1'b0;
    #1;
    checks++; if (req1 !== 1'b0) begin failures++; $display("FAIL stall_hold_c4 got=%b want=0", req1); end
    tick();
    checks++;
    if (instr1 !== 32'h13 || pcd1 !== 32'd0 || pc4_1 !== 32'd4) begin
      failures++; $display("FAIL stall_release got=%h/%h/%h want=13/0/4", instr1, pcd1, pc4_1);
    end
    checks++;
    if (req1 !== 1'b1 || addr1 !== 32'd4) begin
      failures++; $display("FAIL stall_next_addr got=%b/%h want=1/4", req1, addr1);
    end
  endtask

  task automatic test_redirect_wait();
    resp_delay = 3;
    do_reset();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    tick();
    PCSrcE = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      #1;
      checks++;
      if (instr1 !== NOP) begin failures++; $display("FAIL redir_squash_c%0d got=%h want=%h", c, instr1, NOP); end
      if (c == 4) begin
        checks++;
        if (req1 !== 1'b1 || addr1 !== 32'h100) begin
          failures++; $display("FAIL redir_addr got=%b/%h want=1/100", req1, addr1);
        end
      end
      tick();
    end
    checks++;
    if (instr1 !== 32'h4013 || pcd1 !== 32'h100 || pc4_1 !== 32'h104) begin
      failures++; $display("FAIL redir_deliver got=%h/%h/%h want=4013/100/104", instr1, pcd1, pc4_1);
    end
    resp_delay = 1;
  endtask

  task automatic test_redirect_flush();
    do_reset();
    tick();
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
    #1;
    checks++;
    if (instr1 !== NOP || pcd1 !== 32'd0 || pc4_1 !== 32'd0) begin
      failures++; $display("FAIL flush_bubble got=%h/%h/%h want=%h/0/0", instr1, pcd1, pc4_1, NOP);
    end
    checks++;
    if (req1 !== 1'b1 || addr1 !== 32'h200) begin
      failures++; $display("FAIL flush_target got=%b/%h want=1/200", req1, addr1);
    end
    tick();
    tick();
    checks++;
    if (instr1 !== 32'h8013 || pcd1 !== 32'h200 || pc4_1 !== 32'h204) begin
      failures++; $display("FAIL flush_deliver got=%h/%h/%h want=8013/200/204", instr1, pcd1, pc4_1);
    end
  endtask

  task automatic test_not_ready();
    mem_ready = 1'b0;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      checks++;
      if (req1 !== 1'b1 || addr1 !== 32'd0 || instr1 !== NOP) begin
        failures++; $display("FAIL notready_c%0d got=%b/%h/%h want=1/0/%h", c, req1, addr1, instr1, NOP);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (instr1 !== 32'h13 || pcd1 !== 32'd0) begin
      failures++; $display("FAIL notready_deliver got=%h/%h want=13/0", instr1, pcd1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_first_addr got=%b/%h want=1/fffffffc", req2, addr2);
    end
    tick();
    tick();
    checks++;
    if (instr2 !== 32'hFFFF_FF13 || pcd2 !== 32'hFFFF_FFFC || pc4_2 !== 32'd0) begin
      failures++; $display("FAIL wrap_deliver got=%h/%h/%h want=ffffff13/fffffffc/0", instr2, pcd2, pc4_2);
    end
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'd0) begin
      failures++; $display("FAIL wrap_next_addr got=%b/%h want=1/0", req2, addr2);
    end
    // Stall keeps the delivered word in IF/ID so the reset below is observable.
    StallD = 1'b1; resp_delay = 3;
    tick();
    checks++;
    if (instr2 !== 32'hFFFF_FF13 || req2 !== 1'b0) begin
      failures++; $display("FAIL wrap_wait got=%h/%b want=ffffff13/0", instr2, req2);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; StallD = 1'b0; resp_delay = 1;
    #1;
    checks++;
    if (instr2 !== NOP || pcd2 !== 32'd0 || pc4_2 !== 32'd0) begin
      failures++; $display("FAIL wrap_reset_ifid got=%h/%h/%h want=%h/0/0", instr2, pcd2, pc4_2, NOP);
    end
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_reset_req got=%b/%h want=1/fffffffc", req2, addr2);
    end
    tick();
    checks++;
    if (rvalid2 !== 1'b1 || instr2 !== NOP) begin
      failures++; $display("FAIL wrap_reset_resp got=%b/%h want=1/%h", rvalid2, instr2, NOP);
    end
    tick();
    checks++;
    if (instr2 !== 32'hFFFF_FF13 || pcd2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_refetch got=%h/%h want=ffffff13/fffffffc", instr2, pcd2);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_flush();
    test_not_ready();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
